left_shift_unit: RTL and testbench

LEFT_SHIFT_UNIT -- requirements
Module: left_shift_unit

---
 rtl/left_shift_unit_pkg.sv | 31 +++
 rtl/left_shift_unit_left_step.sv | 15 +
 rtl/left_shift_unit.sv | 95 +++++++++
 tb/tb_left_shift_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/left_shift_unit_pkg.sv
// Shared shifter constants: operation encodings, FSM state encodings and the
// per-step fill-bit selection used by the left (and right) shift units.
package left_shift_unit_pkg;

  localparam int DATA_W = 8;
  localparam int AMT_W  = 3;
  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_ROL  = 2'b00;
  localparam logic [MODE_W-1:0] MODE_SHL  = 2'b01;
  localparam logic [MODE_W-1:0] MODE_SHL1 = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Bit shifted into the vacated end on one step; the unused encoding 11
  // falls into the default arm and behaves as a rotate.
  function automatic logic fill_bit(input logic [MODE_W-1:0] mode, input logic carry);
    logic fb;
    case (mode)
      MODE_SHL:  fb = 1'b0;
      MODE_SHL1: fb = 1'b1;
      default:   fb = carry;
    endcase
    return fb;
  endfunction

endpackage

// File: rtl/left_shift_unit_left_step.sv
// Combinational single-bit left step: shifts data up one place, inserts the
// fill bit at bit 0 and exposes the bit that falls off the top.
module left_step
  import left_shift_unit_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic              fill,
  output logic [DATA_W-1:0] shifted,
  output logic              carry
);

  assign carry   = data[DATA_W-1];
  assign shifted = {data[DATA_W-2:0], fill};

endmodule

// File: rtl/left_shift_unit.sv
// Sequential left shifter: captures an operand, shifts it one bit per clock
// for amt cycles, then pulses done with the result held on y.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | waiting for start; y holds the previous result
//   ST_SHIFT | one step per clock while the counter is nonzero (busy=1)
//   ST_DONE  | result valid, done=1 for one cycle; start here chains on
module left_shift_unit
  import left_shift_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [AMT_W-1:0]  amt,
  input  logic [MODE_W-1:0] mode,
  output logic [DATA_W-1:0] y,
  output logic              busy,
  output logic              done
);

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   data_q, data_nxt;
  logic [AMT_W-1:0]    cnt_q, cnt_nxt;
  logic [MODE_W-1:0]   mode_q, mode_nxt;
  logic                busy_q, done_q;

  logic [DATA_W-1:0]   step_data;
  logic                step_carry;
  logic                step_fill;

  assign step_fill = fill_bit(mode_q, step_carry);

  left_step u_left_step (
    .data    (data_q),
    .fill    (step_fill),
    .shifted (step_data),
    .carry   (step_carry)
  );

  always_comb begin
    state_nxt = state;
    data_nxt  = data_q;
    cnt_nxt   = cnt_q;
    mode_nxt  = mode_q;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          data_nxt  = a;
          cnt_nxt   = amt;
          mode_nxt  = mode;
          state_nxt = ST_SHIFT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // Counter only decrements when nonzero, so it can never wrap.
        if (cnt_q != '0) begin
          data_nxt = step_data;
          cnt_nxt  = cnt_q - 1'b1;
        end else begin
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      data_q <= '0;
      cnt_q  <= '0;
      mode_q <= MODE_ROL;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      data_q <= data_nxt;
      cnt_q  <= cnt_nxt;
      mode_q <= mode_nxt;
      // Status flags are registered from the next state so they align with it.
      busy_q <= (state_nxt == ST_SHIFT);
      done_q <= (state_nxt == ST_DONE);
    end
  end

  assign y    = data_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_left_shift_unit.sv
// Directed self-checking bench for left_shift_unit: reset, rotate, fill modes,
// zero amount, ignored start while busy, and a back-to-back exhaustive sweep.
module tb_left_shift_unit;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] a;
  logic [2:0] amt;
  logic [1:0] mode;
  logic [7:0] y;
  logic       busy;
  logic       done;

  int checks;
  int failures;

  left_shift_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .amt     (amt),
    .mode    (mode),
    .y       (y),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: result of shifting a left by n in one shot.
  function automatic logic [7:0] model(input logic [7:0] av, input int n, input logic [1:0] m);
    logic [15:0] w;
    logic [7:0]  ones;
    w    = {8'h00, av} << n;
    ones = 8'((1 << n) - 1);
    if (m == 2'b01)      return w[7:0];
    else if (m == 2'b10) return w[7:0] | ones;
    else                 return w[7:0] | w[15:8];
  endfunction

  // Drive one start pulse, then wait for done. Returns edges from the
  // accept edge to done, busy cycles seen, and a timeout flag.
  task automatic run_op(input logic [7:0] av, input logic [2:0] n, input logic [1:0] m,
                        output int edges, output int busy_cycles, output bit timeout);
    @(negedge clk);
    start = 1'b1; a = av; amt = n; mode = m;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    busy_cycles = 0;
    timeout = 1'b0;
    while (!done && edges < 20) begin
      if (busy) busy_cycles++;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (!done) timeout = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; a = 8'h00; amt = 3'd0; mode = 2'b00;
    #13;
    checks++;
    if (y !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: y=%h busy=%b done=%b required y=00 busy=0 done=0", y, busy, done);
    end
    // Start presented while in reset is taken on the first edge after release.
    @(negedge clk);
    start = 1'b1; a = 8'h3C; amt = 3'd1; mode = 2'b01;
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || y !== 8'h3C) begin
      failures++;
      $display("FAIL first_start: busy=%b y=%h required busy=1 y=3c", busy, y);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (y !== 8'h78) begin
      failures++;
      $display("FAIL first_result: y=%h required 78", y);
    end
  endtask

  task automatic test_rotate;
    int e, b; bit to;
    run_op(8'b1000_0001, 3'd3, 2'b00, e, b, to);
    checks++;
    if (to || e != 4) begin
      failures++;
      $display("FAIL rotate_latency: edges=%0d timeout=%0d required 4", e, to);
    end
    checks++;
    if (y !== 8'b0000_1100) begin
      failures++;
      $display("FAIL rotate_result: y=%b required 00001100", y);
    end
    checks++;
    if (b != 4) begin
      failures++;
      $display("FAIL rotate_busy: busy_cycles=%0d required 4", b);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_in_done: busy=%b required 0", busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || y !== 8'b0000_1100) begin
      failures++;
      $display("FAIL done_single_pulse: done=%b y=%b required done=0 y=00001100", done, y);
    end
  endtask

  task automatic test_fill_modes;
    logic [1:0] modes [3] = '{2'b01, 2'b10, 2'b11};
    logic [7:0] exp   [3] = '{8'hC0, 8'hC3, 8'hC3};
    int e, b; bit to;
    for (int i = 0; i < 3; i++) begin
      run_op(8'hF0, 3'd2, modes[i], e, b, to);
      checks++;
      if (to || y !== exp[i]) begin
        failures++;
        $display("FAIL fill_mode%0d: y=%h timeout=%0d required %h", modes[i], y, to, exp[i]);
      end
    end
  endtask

  task automatic test_zero_amt;
    int e, b; bit to;
    run_op(8'h5A, 3'd0, 2'b01, e, b, to);
    checks++;
    if (to || e != 1 || y !== 8'h5A) begin
      failures++;
      $display("FAIL zero_amt: edges=%0d y=%h timeout=%0d required edges=1 y=5a", e, y, to);
    end
  endtask

  task automatic test_start_during_busy;
    int e;
    @(negedge clk);
    start = 1'b1; a = 8'h01; amt = 3'd7; mode = 2'b00;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    e = 0;
    while (!done && e < 20) begin
      if (e == 3) begin
        start = 1'b1; a = 8'hFF; amt = 3'd0; mode = 2'b10;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      e++;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (!done || e != 8 || y !== 8'h80) begin
      failures++;
      $display("FAIL start_during_busy: edges=%0d done=%b y=%h required edges=8 y=80", e, done, y);
    end
  endtask

  task automatic test_reset_mid_op;
    int seen;
    @(negedge clk);
    start = 1'b1; a = 8'hA5; amt = 3'd5; mode = 2'b00;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (y !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_op: y=%h busy=%b done=%b required y=00 busy=0 done=0", y, busy, done);
    end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_abort: activity_cycles=%0d required 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, prev_done, n, idx, total;
    logic [7:0] cur_a;
    logic [2:0] cur_amt;
    logic [1:0] cur_mode;
    total = 256 * 8 * 4;
    cyc = 0;
    prev_done = -1;
    @(negedge clk);
    start = 1'b1; a = 8'h00; amt = 3'd0; mode = 2'b00;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < total; i++) begin
      cur_a = 8'(i); cur_amt = 3'(i >> 8); cur_mode = 2'(i >> 11);
      @(negedge clk);
      if (i + 1 < total) begin
        idx = i + 1;
        a = 8'(idx); amt = 3'(idx >> 8); mode = 2'(idx >> 11);
      end else begin
        start = 1'b0;
      end
      n = 0;
      while (!done && n < 20) begin
        @(posedge clk);
        cyc++;
        @(negedge clk);
        n++;
      end
      checks++;
      if (!done || y !== model(cur_a, int'(cur_amt), cur_mode)) begin
        failures++;
        $display("FAIL sweep_result a=%h amt=%0d mode=%0d: y=%h done=%b required %h",
                 cur_a, cur_amt, cur_mode, y, done, model(cur_a, int'(cur_amt), cur_mode));
        start = 1'b0;
        return;
      end
      if (prev_done >= 0) begin
        checks++;
        if (cyc - prev_done != int'(cur_amt) + 2) begin
          failures++;
          $display("FAIL sweep_spacing a=%h amt=%0d mode=%0d: gap=%0d required %0d",
                   cur_a, cur_amt, cur_mode, cyc - prev_done, int'(cur_amt) + 2);
        end
      end
      prev_done = cyc;
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL sweep_idle: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_rotate();
    test_fill_modes();
    test_zero_amt();
    test_start_during_busy();
    test_reset_mid_op();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
